// File: rtl/if_prefetch_stage_pkg.sv
// ============================================================================
// Module  : if_pkg
// Brief   : Shared constants and types for the instruction-fetch stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DROP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = c_ST_IDLE,
        S_WAIT = c_ST_WAIT,
        S_DROP = c_ST_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_prefetch_stage_fetch_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Brief   : Synchronous {instr, pc} FIFO; flush wins over push.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import if_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [XLEN-1:0]          pushInstr,
    input  logic [XLEN-1:0]          pushPc,
    input  logic                     pop,
    output logic [XLEN-1:0]          headInstr,
    output logic [XLEN-1:0]          headPc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = DEPTH[c_PTR_W:0];

    logic [XLEN-1:0]    r_instrMem [DEPTH];
    logic [XLEN-1:0]    r_pcMem    [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W:0]   r_count;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            if (pop)  r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_instrMem[r_wrPtr] <= pushInstr;
            r_pcMem[r_wrPtr]    <= pushPc;
        end
    end

    assign headInstr = r_instrMem[r_rdPtr];
    assign headPc    = r_pcMem[r_rdPtr];
    assign count     = r_count;
    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/if_prefetch_stage.sv
// ============================================================================
// Module  : if_prefetch_stage
// Brief   : PC generation, single-outstanding imem requests, prefetch FIFO
//           and IF/ID register. IF_PERF_CNT_EN adds fetch/flush counters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              FETCH_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int              c_CNT_W   = $clog2(FETCH_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = FETCH_DEPTH[c_CNT_W-1:0];
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] c_NOP     = XLEN'(NOP_INSTR);

    fetch_state_e     r_state;
    logic [XLEN-1:0]  r_pcF;
    logic [XLEN-1:0]  r_reqPc;
    logic [XLEN-1:0]  r_instrD;
    logic [XLEN-1:0]  r_pcD;
    logic [XLEN-1:0]  r_pcPlus4D;
    logic             r_validD;

    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_fifoFull;
    logic             w_fifoEmpty;
    logic [c_CNT_W-1:0] w_fifoCount;
    logic [XLEN-1:0]  w_headInstr;
    logic [XLEN-1:0]  w_headPc;

    assign w_issue = !rst && (r_state == S_IDLE) && !PCSrcE && (w_fifoCount < c_DEPTH);
    // Room was reserved at issue; the full guard only keeps a stray push harmless.
    assign w_push  = (r_state == S_WAIT) && imem_rvalid && !PCSrcE && !w_fifoFull;
    assign w_pop   = !PCSrcE && !StallD && !w_fifoEmpty;

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (FETCH_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (PCSrcE),
        .push      (w_push),
        .pushInstr (imem_rdata),
        .pushPc    (r_reqPc),
        .pop       (w_pop),
        .headInstr (w_headInstr),
        .headPc    (w_headPc),
        .count     (w_fifoCount),
        .full      (w_fifoFull),
        .empty     (w_fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pcF   <= RESET_PC;
            r_reqPc <= '0;
        end else begin
            if (PCSrcE) r_pcF <= PCTargetE;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_reqPc <= r_pcF;
                        r_pcF   <= r_pcF + c_PC_STEP;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid)  r_state <= S_IDLE;
                    else if (PCSrcE)  r_state <= S_DROP;
                end
                S_DROP: begin
                    if (imem_rvalid)  r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instrD   <= c_NOP;
            r_pcD      <= '0;
            r_pcPlus4D <= '0;
            r_validD   <= 1'b0;
        end else if (PCSrcE) begin
            r_instrD <= c_NOP;
            r_validD <= 1'b0;
        end else if (!StallD) begin
            if (w_pop) begin
                r_instrD   <= w_headInstr;
                r_pcD      <= w_headPc;
                r_pcPlus4D <= w_headPc + c_PC_STEP;
                r_validD   <= 1'b1;
            end else begin
                r_instrD <= c_NOP;
                r_validD <= 1'b0;
            end
        end
    end

    assign imem_req  = w_issue;
    assign imem_addr = r_pcF;
    assign PCF       = r_pcF;
    assign InstrD    = r_instrD;
    assign PCD       = r_pcD;
    assign PCPlus4D  = r_pcPlus4D;
    assign ValidD    = r_validD;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perfFetch;
    logic [31:0] r_perfFlush;

    // A redirect in WAIT loses the in-flight response as well as the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perfFetch <= '0;
            r_perfFlush <= '0;
        end else begin
            if (w_pop)  r_perfFetch <= r_perfFetch + 32'd1;
            if (PCSrcE) r_perfFlush <= r_perfFlush + 32'(w_fifoCount)
                                       + {31'd0, (r_state == S_WAIT)};
        end
    end

    assign perf_fetch_cnt = r_perfFetch;
    assign perf_flush_cnt = r_perfFlush;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
// ============================================================================
// Module  : tb_if_prefetch_stage
// Brief   : Directed checks of the fetch stage against a variable-latency
//           memory model; perf counters checked when IF_PERF_CNT_EN is set.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_if_prefetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, PCSrcE, StallD, imem_rvalid;
    logic [31:0] PCTargetE, imem_rdata;
    logic        imem_req, ValidD, wReq, wValid;
    logic [31:0] imem_addr, PCF, InstrD, PCD, PCPlus4D;
    logic [31:0] wAddr, wPCF, wInstrD, wPCD, wPCPlus4D;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perfFetch, perfFlush, wPerfFetch, wPerfFlush;
`endif

    if_prefetch_stage #(.XLEN(32), .FETCH_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perfFetch), .perf_flush_cnt(perfFlush)
`endif
    );

    // Runs in lockstep with dut (handshake timing is address-independent).
    if_prefetch_stage #(.XLEN(32), .FETCH_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .imem_req(wReq), .imem_addr(wAddr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .PCF(wPCF), .InstrD(wInstrD), .PCD(wPCD),
        .PCPlus4D(wPCPlus4D), .ValidD(wValid)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(wPerfFetch), .perf_flush_cnt(wPerfFlush)
`endif
    );

    typedef struct {
        bit          src;
        logic [31:0] tgt;
        bit          stall;
        bit          expReq;
        logic [31:0] expAddr;
        logic [31:0] expWAddr;
        bit          expValid;
        logic [31:0] expPcD;
        logic [31:0] expP4;
        logic [31:0] expInstr;
    } vec_t;

    vec_t        vecs[9];
    int          total = 0;
    int          bad   = 0;
    int          lat   = 1;
    bit          pend  = 1'b0;
    int          cnt   = 0;
    logic [31:0] pAddr = '0;
    bit          reqSeen, wReqSeen;
    logic [31:0] reqAddr, wReqAddr;
    logic [31:0] flushBase;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic vec_t mk(input bit r, input logic [31:0] a, input logic [31:0] wa,
                                input bit v, input logic [31:0] pd, input logic [31:0] p4,
                                input logic [31:0] ins);
        vec_t t;
        t.src = 1'b0; t.tgt = '0; t.stall = 1'b0;
        t.expReq = r; t.expAddr = a; t.expWAddr = wa;
        t.expValid = v; t.expPcD = pd; t.expP4 = p4; t.expInstr = ins;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, sample combinational request, take the edge.
    task automatic cyc(input bit src, input logic [31:0] tgt, input bit stall);
        PCSrcE = src; PCTargetE = tgt; StallD = stall;
        imem_rvalid = 1'b0; imem_rdata = '0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instrOf(pAddr);
                pend        = 1'b0;
            end
        end
        #1;
        reqSeen = imem_req; reqAddr = imem_addr;
        wReqSeen = wReq; wReqAddr = wAddr;
        @(posedge clk); #1;
        if (reqSeen) begin
            pend = 1'b1; cnt = lat; pAddr = reqAddr;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        chk("req_during_rst0", {31'd0, reqSeen}, 32'd0);
        cyc(1'b0, '0, 1'b0);
        chk("req_during_rst1", {31'd0, reqSeen}, 32'd0);
        rst  = 1'b0;
        pend = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(1, 32'h00, 32'hFFFF_FFF8, 0, 32'h0, 32'h0,  32'h13);
        vecs[1] = mk(0, 32'h00, 32'h0,         0, 32'h0, 32'h0,  32'h13);
        vecs[2] = mk(1, 32'h04, 32'hFFFF_FFFC, 1, 32'h0, 32'h4,  instrOf(32'h0));
        vecs[3] = mk(0, 32'h00, 32'h0,         0, 32'h0, 32'h4,  32'h13);
        vecs[4] = mk(1, 32'h08, 32'h0000_0000, 1, 32'h4, 32'h8,  instrOf(32'h4));
        vecs[5] = mk(0, 32'h00, 32'h0,         0, 32'h4, 32'h8,  32'h13);
        vecs[6] = mk(1, 32'h0C, 32'h0000_0004, 1, 32'h8, 32'hC,  instrOf(32'h8));
        vecs[7] = mk(0, 32'h00, 32'h0,         0, 32'h8, 32'hC,  32'h13);
        vecs[8] = mk(1, 32'h10, 32'h0000_0008, 1, 32'hC, 32'h10, instrOf(32'hC));

        // Reset state
        lat = 1;
        doReset();
        chk("rst_PCF", PCF, 32'h0);
        chk("rst_ValidD", {31'd0, ValidD}, 32'd0);
        chk("rst_InstrD", InstrD, 32'h13);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_wrap_PCF", wPCF, 32'hFFFF_FFF8);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetch", perfFetch, 32'd0);
        chk("rst_perf_flush", perfFlush, 32'd0);
`endif

        // Sequential fetch with latency 1, plus wrap instance addresses
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].src, vecs[i].tgt, vecs[i].stall);
            chk($sformatf("seq%0d_req", i), {31'd0, reqSeen}, {31'd0, vecs[i].expReq});
            if (vecs[i].expReq) begin
                chk($sformatf("seq%0d_addr", i), reqAddr, vecs[i].expAddr);
                chk($sformatf("seq%0d_wrap_addr", i), wReqAddr, vecs[i].expWAddr);
            end
            chk($sformatf("seq%0d_ValidD", i), {31'd0, ValidD}, {31'd0, vecs[i].expValid});
            chk($sformatf("seq%0d_PCD", i), PCD, vecs[i].expPcD);
            chk($sformatf("seq%0d_PCPlus4D", i), PCPlus4D, vecs[i].expP4);
            chk($sformatf("seq%0d_InstrD", i), InstrD, vecs[i].expInstr);
        end

        // Decode stall: queue fills to 4, requests stop, IF/ID holds
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk($sformatf("stall%0d_InstrD", i), InstrD, instrOf(32'hC));
            chk($sformatf("stall%0d_ValidD", i), {31'd0, ValidD}, 32'd1);
            if (i >= 6) chk($sformatf("stall%0d_req", i), {31'd0, reqSeen}, 32'd0);
        end
        chk("stall_PCF", PCF, 32'h20);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b0);
            if (i == 0) chk("release_req_full", {31'd0, reqSeen}, 32'd0);
            chk($sformatf("release%0d_ValidD", i), {31'd0, ValidD}, 32'd1);
            chk($sformatf("release%0d_PCD", i), PCD, 32'h10 + 32'(4 * i));
            chk($sformatf("release%0d_InstrD", i), InstrD, instrOf(32'h10 + 32'(4 * i)));
        end

        // Redirect while a latency-3 request is in flight
        lat = 3;
        doReset();
        cyc(1'b0, '0, 1'b0);
        chk("redir_first_req", {31'd0, reqSeen}, 32'd1);
        chk("redir_first_addr", reqAddr, 32'h0);
        cyc(1'b1, 32'h28, 1'b0);
        chk("redir_PCF", PCF, 32'h28);
        chk("redir_ValidD", {31'd0, ValidD}, 32'd0);
        cyc(1'b0, '0, 1'b0);
        chk("drop_req_a", {31'd0, reqSeen}, 32'd0);
        cyc(1'b0, '0, 1'b0);
        chk("drop_req_b", {31'd0, reqSeen}, 32'd0);
        chk("drop_ValidD", {31'd0, ValidD}, 32'd0);
        cyc(1'b0, '0, 1'b0);
        chk("target_req", {31'd0, reqSeen}, 32'd1);
        chk("target_addr", reqAddr, 32'h28);
        begin
            int n;
            n = 0;
            while (!ValidD && n < 12) begin
                cyc(1'b0, '0, 1'b0);
                n++;
            end
            chk("target_latency", n, 4);
            chk("target_PCD", PCD, 32'h28);
            chk("target_InstrD", InstrD, instrOf(32'h28));
        end

        // Redirect together with StallD and an arriving response
        lat = 1;
        doReset();
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("rs_pre_ValidD", {31'd0, ValidD}, 32'd1);
        chk("rs_pre_PCD", PCD, 32'h0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("rs_req8", reqAddr, 32'h8);
`ifdef IF_PERF_CNT_EN
        chk("rs_perf_fetch1", perfFetch, 32'd1);
        flushBase = perfFlush;
`else
        flushBase = '0;
`endif
        cyc(1'b1, 32'h100, 1'b1);
        chk("rs_ValidD", {31'd0, ValidD}, 32'd0);
        chk("rs_InstrD", InstrD, 32'h13);
        chk("rs_PCF", PCF, 32'h100);
`ifdef IF_PERF_CNT_EN
        chk("rs_perf_flush", perfFlush, flushBase + 32'd2);
`endif
        cyc(1'b0, '0, 1'b0);
        chk("rs_req_target", {31'd0, reqSeen}, 32'd1);
        chk("rs_addr_target", reqAddr, 32'h100);
        chk("rs_fifo_empty", {31'd0, ValidD}, 32'd0);
        cyc(1'b0, '0, 1'b0);
        chk("rs_bubble", {31'd0, ValidD}, 32'd0);
        cyc(1'b0, '0, 1'b0);
        chk("rs_ValidD_tgt", {31'd0, ValidD}, 32'd1);
        chk("rs_PCD_tgt", PCD, 32'h100);
        chk("rs_PCPlus4D_tgt", PCPlus4D, 32'h104);
        chk("rs_InstrD_tgt", InstrD, instrOf(32'h100));
`ifdef IF_PERF_CNT_EN
        chk("rs_perf_fetch2", perfFetch, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
